// File: rtl/iob_cache_write_through_buffer.sv
// Write-through buffer: in-order queue of word writes to the AXI write channel, merging into the youngest entry.
// Head is registered (1-cycle push-to-valid latency); valid/ready drain, pushes dropped only when full and not mergeable.
module iob_cache_write_through_buffer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     push,
  input  logic [ADDR_W-$clog2(DATA_W/8)-1:0]       push_addr,
  input  logic [DATA_W-1:0]                        push_wdata,
  input  logic [DATA_W/8-1:0]                      push_wstrb,
  output logic                                     full,
  output logic                                     empty,
  output logic [DEPTH_W:0]                         level,
  output logic                                     write_valid,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]       write_addr,
  output logic [DATA_W-1:0]                        write_wdata,
  output logic [DATA_W/8-1:0]                      write_wstrb,
  input  logic                                     write_ready
);

  localparam int NBYTES   = DATA_W / 8;
  localparam int NBYTES_W = $clog2(NBYTES);
  localparam int AW       = ADDR_W - NBYTES_W;
  localparam int DEPTH    = 2 ** DEPTH_W;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wdata;
    logic [NBYTES-1:0] wstrb;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] last_ptr;
  logic               merge;
  logic               append;
  logic               pop;

  assign last_ptr    = wr_ptr - DEPTH_W'(1);
  assign full        = (level == (DEPTH_W+1)'(DEPTH));
  assign empty       = (level == '0);
  assign write_valid = (level != '0);
  assign write_addr  = mem[rd_ptr].addr;
  assign write_wdata = mem[rd_ptr].wdata;
  assign write_wstrb = mem[rd_ptr].wstrb;

  // level >= 2 keeps the head (possibly mid-transfer) out of reach of a merge
  assign merge  = push && (level >= (DEPTH_W+1)'(2)) && (push_addr == mem[last_ptr].addr);
  assign append = push && !merge && !full;
  assign pop    = write_valid && write_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (append) wr_ptr <= wr_ptr + DEPTH_W'(1);
      if (pop)    rd_ptr <= rd_ptr + DEPTH_W'(1);
      case ({append, pop})
        2'b10:   level <= level + (DEPTH_W+1)'(1);
        2'b01:   level <= level - (DEPTH_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is cleared on reset so the head fields read zero afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (append) begin
      mem[wr_ptr].addr  <= push_addr;
      mem[wr_ptr].wdata <= push_wdata;
      mem[wr_ptr].wstrb <= push_wstrb;
    end else if (merge) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (push_wstrb[b]) begin
          mem[last_ptr].wdata[8*b +: 8] <= push_wdata[8*b +: 8];
          mem[last_ptr].wstrb[b]        <= 1'b1;
        end
      end
    end
  end

endmodule
